oldland_imem: RTL and testbench

Instruction-memory responder for the fetch port of the Oldland core. It returns instruction words for the fetch stage's i_addr/i_data interface and adds an access/acknowledge handshake with programmable wait states. It also provides a loader write port so a program can be downloaded into the array before or while the core runs.

---
 rtl/oldland_imem_pkg.sv | 20 ++
 rtl/oldland_imem_ram.sv | 45 ++++
 rtl/oldland_imem.sv | 108 ++++++++++
 tb/tb_oldland_imem.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/oldland_imem_pkg.sv
// Shared definitions for the Oldland instruction-memory responder.
// Fetch FSM encoding, wait-counter width and the default idle/out-of-range fetch word.
package oldland_imem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_READ = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  localparam int WAIT_CNT_W = 4;

  localparam logic [31:0] RESET_DATA_DEFAULT = 32'h0000_0000;

  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/oldland_imem_ram.sv
// Instruction word array: one loader write port and one registered read port.
// A same-cycle read and write to one word returns the old contents. Parity column with OLDLAND_IMEM_PARITY_EN.
module oldland_imem_ram
  import oldland_imem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [31:0]          wr_data,
`ifdef OLDLAND_IMEM_PARITY_EN
  input  logic                 wr_bad_parity,
`endif
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [31:0]          rd_data,
  output logic                 rd_parity_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

`ifdef OLDLAND_IMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic rd_par;

  // wr_bad_parity flips the stored bit so a fault can be planted from the loader.
  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_addr] <= even_parity(wr_data) ^ wr_bad_parity;
    if (rd_en) rd_par <= par_mem[rd_addr];
  end

  assign rd_parity_err = even_parity(rd_data) ^ rd_par;
`else
  assign rd_parity_err = 1'b0;
`endif

endmodule

// File: rtl/oldland_imem.sv
// Oldland fetch-port instruction memory: access/ack handshake with WAIT_STATES cycles of delay
// and a loader write port. Define OLDLAND_IMEM_PARITY_EN for per-word parity checking.
module oldland_imem
  import oldland_imem_pkg::*;
#(
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_DATA  = RESET_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_access,
  input  logic [31:0]          i_addr,
  output logic                 i_ack,
  output logic [31:0]          i_data,
  output logic                 i_error,
  input  logic                 ld_wr_en,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [31:0]          ld_data,
`ifdef OLDLAND_IMEM_PARITY_EN
  input  logic                 ld_bad_parity,
`endif
  output logic                 busy
);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("oldland_imem: WAIT_STATES must be in 0..15");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > 29) begin : g_bad_addr_bits
      $error("oldland_imem: ADDR_BITS must be in 1..29");
    end
  endgenerate

  state_t                 state;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   oor_q;
  logic                   resp_oor;
  logic                   accept;
  logic                   req_oor;
  logic [31:0]            ram_data;
  logic                   ram_par_err;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^i_addr[1:0];

  assign accept  = i_access && (state == ST_IDLE || state == ST_RESP);
  assign req_oor = |i_addr[31:ADDR_BITS+2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      resp_oor <= 1'b1;
    end else begin
      unique case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == WAIT_CNT_W'(1)) state <= ST_READ;
        end
        ST_READ: begin
          state    <= ST_RESP;
          resp_oor <= oor_q;
        end
        default: begin
          if (accept) begin
            state    <= (WAIT_STATES == 0) ? ST_READ : ST_WAIT;
            wait_cnt <= WAIT_STATES[WAIT_CNT_W-1:0];
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Request capture; only meaningful once a fetch has been accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= i_addr[ADDR_BITS+1:2];
      oor_q  <= req_oor;
    end
  end

  oldland_imem_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk          (clk),
    .wr_en        (ld_wr_en),
    .wr_addr      (ld_addr),
    .wr_data      (ld_data),
`ifdef OLDLAND_IMEM_PARITY_EN
    .wr_bad_parity(ld_bad_parity),
`endif
    .rd_en        (state == ST_READ && !oor_q),
    .rd_addr      (addr_q),
    .rd_data      (ram_data),
    .rd_parity_err(ram_par_err)
  );

  // ram_data and resp_oor both change only on entry to RESP, so i_data holds between acks.
  assign i_ack   = (state == ST_RESP);
  assign i_data  = resp_oor ? RESET_DATA : ram_data;
  assign i_error = i_ack && (resp_oor || ram_par_err);
  assign busy    = (state == ST_WAIT) || (state == ST_READ) || (state == ST_RESP && i_access);

endmodule

// File: tb/tb_oldland_imem.sv
// Directed bench for oldland_imem: three instances (WAIT_STATES 0, 3, 2) share one stimulus stream.
// Parity fault case is included when OLDLAND_IMEM_PARITY_EN is defined.
module tb_oldland_imem;

  logic        clk;
  logic        rst_n;
  logic        i_access;
  logic [31:0] i_addr;
  logic        ld_wr_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_bad_parity;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [2:0]  busy;
  logic [31:0] data [3];

  int n_checks = 0;
  int n_fail   = 0;

  localparam int WS [3] = '{0, 3, 2};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    oldland_imem #(
      .ADDR_BITS  (10),
      .WAIT_STATES(WS[g]),
      .RESET_DATA (32'h0000_0000)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_access     (i_access),
      .i_addr       (i_addr),
      .i_ack        (ack[g]),
      .i_data       (data[g]),
      .i_error      (err[g]),
      .ld_wr_en     (ld_wr_en),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
`ifdef OLDLAND_IMEM_PARITY_EN
      .ld_bad_parity(ld_bad_parity),
`endif
      .busy         (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_wr_en = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    tick();
    ld_wr_en = 1'b0;
  endtask

  task automatic fetch_start(input logic [31:0] a);
    i_access = 1'b1;
    i_addr   = a;
    tick();
    i_access = 1'b0;
  endtask

  initial begin
    int nacks;
    rst_n = 1'b0; i_access = 1'b0; i_addr = '0;
    ld_wr_en = 1'b0; ld_addr = '0; ld_data = '0; ld_bad_parity = 1'b0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_ack", ack[k], 0);
      check("rst_err", err[k], 0);
      check("rst_busy", busy[k], 0);
      check("rst_data", data[k], 32'h0);
    end
    rst_n = 1'b1;
    load(10'd5, 32'hDEADBEEF);
    load(10'd0, 32'h12345678);
    load(10'd7, 32'hAAAA0000);

    // basic fetch, zero wait states
    fetch_start(32'h14);
    check("t1_c1_ack", ack[0], 0);
    check("t1_c1_busy", busy[0], 1);
    tick();
    check("t1_ack", ack[0], 1);
    check("t1_data", data[0], 32'hDEADBEEF);
    check("t1_err", err[0], 0);
    tick();
    check("t1_c3_ack", ack[0], 0);
    check("t1_hold", data[0], 32'hDEADBEEF);
    repeat (3) tick();

    // wait-state latency and busy window
    fetch_start(32'h0);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("t2_ack3_c%0d", k), ack[1], k == 5);
      check($sformatf("t2_busy3_c%0d", k), busy[1], k < 5);
      check($sformatf("t2_ack2_c%0d", k), ack[2], k == 4);
      if (k == 5) check("t2_data3", data[1], 32'h12345678);
      tick();
    end

    // out-of-range fetch
    fetch_start(32'h0000_1000);
    tick();
    check("t3_ack", ack[0], 1);
    check("t3_err", err[0], 1);
    check("t3_data", data[0], 32'h0);
    repeat (4) tick();

    // loader write colliding with the array read
    fetch_start(32'h1C);
    ld_wr_en = 1'b1; ld_addr = 10'd7; ld_data = 32'h5555FFFF;
    tick();
    ld_wr_en = 1'b0;
    check("t4_ack", ack[0], 1);
    check("t4_old", data[0], 32'hAAAA0000);
    repeat (4) tick();
    fetch_start(32'h1C);
    tick();
    check("t4_new", data[0], 32'h5555FFFF);
    repeat (4) tick();

    // back-to-back requests, zero wait states
    i_access = 1'b1; i_addr = 32'h14;
    tick();
    check("tp_c1_ack", ack[0], 0);
    tick();
    check("tp_c2_ack", ack[0], 1);
    check("tp_c2_busy", busy[0], 1);
    tick();
    i_access = 1'b0;
    check("tp_c3_ack", ack[0], 0);
    tick();
    check("tp_c4_ack", ack[0], 1);
    check("tp_c4_busy", busy[0], 0);
    repeat (3) tick();

    // reset while waiting aborts the fetch
    fetch_start(32'h14);
    check("t5_wait_busy", busy[2], 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_rst_data", data[2], 32'h0);
    nacks = 0;
    repeat (8) begin
      tick();
      if (ack[2]) nacks++;
    end
    check("t5_noack", nacks, 0);
    check("t5_data", data[2], 32'h0);
    check("t5_busy", busy[2], 0);
    fetch_start(32'h14);
    repeat (3) tick();
    check("t5_new_ack", ack[2], 1);
    check("t5_new_data", data[2], 32'hDEADBEEF);
    repeat (3) tick();

`ifdef OLDLAND_IMEM_PARITY_EN
    ld_bad_parity = 1'b1;
    load(10'd3, 32'h1);
    ld_bad_parity = 1'b0;
    fetch_start(32'hC);
    tick();
    check("t6_ack", ack[0], 1);
    check("t6_err", err[0], 1);
    check("t6_data", data[0], 32'h1);
    repeat (4) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
